// File: rtl/zmc2_serializer.sv
// NeoGeo sprite pixel serializer: one 8-pixel, 4-plane C-ROM line in,
// two 4-bit colour indices per clock out, with H-flip and pair ordering.
module zmc2_serializer (
    input  logic        CLK_12M,
    input  logic        nRESET,
    input  logic        EVEN,
    input  logic        LOAD,
    input  logic        H,
    input  logic [31:0] CR,
    output logic [3:0]  GAD,
    output logic [3:0]  GBD,
    output logic        DOTA,
    output logic        DOTB
);

    logic [31:0] sr_q;
    logic [31:0] sr_d;
    logic [3:0]  x_s;
    logic [3:0]  y_s;

    // Each plane moves two columns per clock; vacated columns become transparent.
    always_comb begin
        sr_d = sr_q;
        if (LOAD) begin
            sr_d = CR;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (H) begin
                    sr_d[p*8 +: 8] = {sr_q[p*8 +: 6], 2'b00};
                end else begin
                    sr_d[p*8 +: 8] = {2'b00, sr_q[p*8+2 +: 6]};
                end
            end
        end
    end

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            sr_q <= 32'h0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // Leading pixel pair sits at the LSB end unflipped, at the MSB end flipped.
    always_comb begin
        x_s = 4'h0;
        y_s = 4'h0;
        for (int p = 0; p < 4; p++) begin
            x_s[p] = H ? sr_q[p*8+7] : sr_q[p*8];
            y_s[p] = H ? sr_q[p*8+6] : sr_q[p*8+1];
        end
    end

    assign GAD  = EVEN ? x_s : y_s;
    assign GBD  = EVEN ? y_s : x_s;
    assign DOTA = |GAD;
    assign DOTB = |GBD;

endmodule

// File: tb/tb_zmc2_serializer.sv
// Self-checking bench for zmc2_serializer: directed cases plus randomized
// traffic compared against a pixel-column model of the sprite line.
module tb_zmc2_serializer;

    logic        clk;
    logic        rst_n;
    logic        even;
    logic        load;
    logic        h;
    logic [31:0] cr;
    logic [3:0]  gad;
    logic [3:0]  gbd;
    logic        dota;
    logic        dotb;

    int checks;
    int failures;

    // Model: eight pixel columns, each a 4-bit colour index.
    logic [3:0] m_pix [8];

    zmc2_serializer dut (
        .CLK_12M(clk),
        .nRESET (rst_n),
        .EVEN   (even),
        .LOAD   (load),
        .H      (h),
        .CR     (cr),
        .GAD    (gad),
        .GBD    (gbd),
        .DOTA   (dota),
        .DOTB   (dotb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_pix[i] = 4'h0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic [3:0] nx [8];
        if (!rst_n) begin
            model_clear();
            return;
        end
        for (int i = 0; i < 8; i++) begin
            if (load) begin
                nx[i] = {cr[24+i], cr[16+i], cr[8+i], cr[i]};
            end else if (!h) begin
                nx[i] = (i + 2 < 8) ? m_pix[i+2] : 4'h0;
            end else begin
                nx[i] = (i >= 2) ? m_pix[i-2] : 4'h0;
            end
        end
        for (int i = 0; i < 8; i++) m_pix[i] = nx[i];
    endtask

    // Returns {GAD, GBD} expected from the model's current pixels.
    function automatic logic [7:0] model_out(input logic hh, input logic ev);
        logic [3:0] first;
        logic [3:0] second;
        first  = hh ? m_pix[7] : m_pix[0];
        second = hh ? m_pix[6] : m_pix[1];
        return ev ? {first, second} : {second, first};
    endfunction

    task automatic step(input logic ld, input logic [31:0] d,
                        input logic hh, input logic ev);
        load = ld;
        cr   = d;
        h    = hh;
        even = ev;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        checks++;
        if (gad !== 4'hF || gbd !== 4'hF) begin
            failures++;
            $display("FAIL reset_preload gad=%h gbd=%h want F/F", gad, gbd);
        end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (gad !== 4'h0 || gbd !== 4'h0 || dota !== 1'b0 || dotb !== 1'b0) begin
            failures++;
            $display("FAIL reset_async gad=%h gbd=%h dota=%b dotb=%b want 0",
                     gad, gbd, dota, dotb);
        end
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        checks++;
        if (gad !== 4'h0 || gbd !== 4'h0 || dota !== 1'b0 || dotb !== 1'b0) begin
            failures++;
            $display("FAIL reset_over_load gad=%h gbd=%h want 0", gad, gbd);
        end
        #2;
        rst_n = 1'b1;
        load  = 1'b0;
        #1;
        checks++;
        if (gad !== 4'h0 || gbd !== 4'h0) begin
            failures++;
            $display("FAIL reset_release gad=%h gbd=%h want 0", gad, gbd);
        end
    endtask

    task automatic test_full_drain();
        for (int c = 0; c < 5; c++) begin
            logic [3:0] e;
            step(c == 0, 32'hFFFF_FFFF, 1'b0, 1'b1);
            e = (c < 4) ? 4'hF : 4'h0;
            checks++;
            if (gad !== e || gbd !== e || dota !== (c < 4) || dotb !== (c < 4)) begin
                failures++;
                $display("FAIL drain_c%0d gad=%h gbd=%h dota=%b dotb=%b want %h",
                         c, gad, gbd, dota, dotb, e);
            end
        end
    endtask

    task automatic test_order_unflipped();
        for (int ev = 1; ev >= 0; ev--) begin
            for (int c = 0; c < 4; c++) begin
                logic [3:0] ea;
                logic [3:0] eb;
                step(c == 0, 32'h0000_0001, 1'b0, ev[0]);
                ea = (c == 0 && ev == 1) ? 4'h1 : 4'h0;
                eb = (c == 0 && ev == 0) ? 4'h1 : 4'h0;
                checks++;
                if (gad !== ea || gbd !== eb) begin
                    failures++;
                    $display("FAIL order_h0_e%0d_c%0d gad=%h gbd=%h want %h/%h",
                             ev, c, gad, gbd, ea, eb);
                end
            end
        end
    endtask

    task automatic test_order_flipped();
        for (int c = 0; c < 4; c++) begin
            logic [3:0] eb;
            step(c == 0, 32'h0000_0001, 1'b1, 1'b1);
            eb = (c == 3) ? 4'h1 : 4'h0;
            checks++;
            if (gad !== 4'h0 || gbd !== eb || dotb !== (c == 3)) begin
                failures++;
                $display("FAIL order_h1_c%0d gad=%h gbd=%h dotb=%b want 0/%h",
                         c, gad, gbd, dotb, eb);
            end
        end
    endtask

    task automatic test_plane_map();
        step(1'b1, 32'h8000_0000, 1'b1, 1'b1);
        checks++;
        if (gad !== 4'h8 || gbd !== 4'h0) begin
            failures++;
            $display("FAIL plane3_flip gad=%h gbd=%h want 8/0", gad, gbd);
        end
        step(1'b1, 32'h0000_0200, 1'b0, 1'b1);
        checks++;
        if (gbd !== 4'h2 || gad !== 4'h0) begin
            failures++;
            $display("FAIL plane1_col1 gad=%h gbd=%h want 0/2", gad, gbd);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 32'h0000_0001, 1'b0, 1'b1);
        checks++;
        if (gad !== 4'h1) begin
            failures++;
            $display("FAIL reload_first gad=%h want 1", gad);
        end
        step(1'b1, 32'h0000_0101, 1'b0, 1'b1);
        checks++;
        if (gad !== 4'h3 || gbd !== 4'h0) begin
            failures++;
            $display("FAIL reload_second gad=%h gbd=%h want 3/0", gad, gbd);
        end
    endtask

    task automatic test_random();
        logic [7:0] e;
        logic       hh;
        hh = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) hh = ~hh;
            load = ($urandom_range(0, 3) == 0);
            cr   = $urandom;
            h    = hh;
            even = $urandom_range(0, 1);
            #1;
            e = model_out(h, even);
            checks++;
            if ({gad, gbd} !== e || dota !== |e[7:4] || dotb !== |e[3:0]) begin
                failures++;
                $display("FAIL rand_comb_%0d gad=%h gbd=%h dota=%b dotb=%b want %h/%h",
                         n, gad, gbd, dota, dotb, e[7:4], e[3:0]);
            end
            model_edge();
            @(posedge clk);
            #1;
            e = model_out(h, even);
            checks++;
            if ({gad, gbd} !== e || dota !== |e[7:4] || dotb !== |e[3:0]) begin
                failures++;
                $display("FAIL rand_edge_%0d gad=%h gbd=%h dota=%b dotb=%b want %h/%h",
                         n, gad, gbd, dota, dotb, e[7:4], e[3:0]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        h        = 1'b0;
        even     = 1'b1;
        cr       = 32'h0;
        model_clear();
        #12;
        rst_n = 1'b1;
        test_reset();
        test_full_drain();
        test_order_unflipped();
        test_order_flipped();
        test_plane_map();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
